// File: rtl/dft_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 11x12 unsigned multiplier among N_REQ requesters.
// Define DFT_MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

module dft_mul_mul_11ns_12ns_23_4_1 (
  input  logic        clk,
  input  logic        ce,
  input  logic [10:0] din0,
  input  logic [11:0] din1,
  output logic [22:0] dout
);
  logic [10:0] a_p0;
  logic [11:0] b_p0;
  logic [22:0] prod_p1;
  logic [22:0] prod_p2;

  // Stage p0: operand capture; p1: product; p2: output register. Data-only, never reset.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_p0    <= din0;
      b_p0    <= din1;
      prod_p1 <= {12'd0, a_p0} * {11'd0, b_p0};
      prod_p2 <= prod_p1;
    end
  end

  assign dout = prod_p2;
endmodule

module dft_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*11-1:0]   req_a,
  input  logic [N_REQ*12-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [22:0]           rsp_p,
  input  logic                  rsp_ready,
  output logic                  busy
);
  localparam int DATA_W = 11;
  localparam int COEF_W = 12;

  logic              adv;
  logic              gnt_any;
  logic [ID_W-1:0]   gnt_idx;
  logic              issue;
  logic [DATA_W-1:0] mul_a;
  logic [COEF_W-1:0] mul_b;
  logic [22:0]       mul_dout;

  logic              vld_p0, vld_p1, vld_p2;
  logic [ID_W-1:0]   id_p0, id_p1, id_p2;

  // A held response freezes the multiplier and every tag stage together.
  assign adv   = !(rsp_valid && !rsp_ready);
  assign issue = adv && gnt_any;

`ifdef DFT_MUL_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int j;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ptr <= ID_W'(N_REQ - 1);
    else if (issue) ptr <= gnt_idx;
  end
`endif

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (issue && gnt_idx == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[i*DATA_W +: DATA_W];
        mul_b        = req_b[i*COEF_W +: COEF_W];
      end
    end
  end

  dft_mul_mul_11ns_12ns_23_4_1 u_mul (
    .clk  (clk),
    .ce   (adv),
    .din0 (mul_a),
    .din1 (mul_b),
    .dout (mul_dout)
  );

  // Stages p0..p2 mirror the multiplier registers; the 4th stage is the response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      id_p0     <= '0;
      id_p1     <= '0;
      id_p2     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else if (adv) begin
      vld_p0    <= issue;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      id_p0     <= gnt_idx;
      id_p1     <= id_p0;
      id_p2     <= id_p1;
      rsp_valid <= vld_p2;
      rsp_id    <= id_p2;
      if (vld_p2) rsp_p <= mul_dout;
    end
  end

  assign busy = vld_p0 | vld_p1 | vld_p2 | rsp_valid;
endmodule

// File: tb/tb_dft_mul_arbiter.sv
// Randomized and directed bench for dft_mul_arbiter with a queue-based behavioural model.
module tb_dft_mul_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*11-1:0] req_a = '0;
  logic [N*12-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [22:0]    rsp_p;
  logic           rsp_ready = 1'b1;
  logic           busy;

  dft_mul_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int p; int n;} item_t;
  item_t q[$];
  int nadv, mptr, last_p;
  int checks = 0, errors = 0, cyc = 0;
  int log_p[$], log_c[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(int i, int a, int b);
    req_a[i*11 +: 11] = a[10:0];
    req_b[i*12 +: 12] = b[11:0];
  endtask

  // Every issued op is reported after four advancing edges, in issue order.
  task automatic model_check();
    bit ev, adv;
    int g;
    logic [N-1:0] eg;
    ev = q.size() > 0 && nadv >= q[0].n + 4;
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_p", rsp_p, q[0].p);
      last_p = q[0].p;
    end else begin
      chk("rsp_p_hold", rsp_p, last_p);
    end
    chk("busy", busy, q.size() > 0);
    adv = !(ev && !rsp_ready);
    g = -1;
    if (adv) begin
`ifdef DFT_MUL_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (g < 0 && req_valid[k]) g = k;
`else
      for (int k = 1; k <= N; k++) if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
`endif
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", req_ready, eg);
    if (rsp_valid && rsp_ready) begin
      log_p.push_back(int'(rsp_p));
      log_c.push_back(cyc);
    end
    if (ev && rsp_ready) void'(q.pop_front());
    if (adv) begin
      if (g >= 0) begin
        q.push_back('{g, int'(req_a[g*11 +: 11]) * int'(req_b[g*12 +: 12]), nadv});
        mptr = g;
      end
      nadv++;
    end
  endtask

  task automatic step();
    #1;
    model_check();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_p", rsp_p, 0);
    chk("reset_req_ready", req_ready, 0);
    q.delete();
    nadv = 0;
    mptr = N - 1;
    last_p = 0;
    log_p.delete();
    log_c.delete();
    cyc = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int issued, stall_left, held;
    bit stalled_once, acc;
    #2;
    do_reset();

    // Single op at the extreme operand values.
    set_op(2, 2047, 4095);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      chk("single_busy", busy, 1);
      chk("single_early", rsp_valid, 0);
      step();
    end
    chk("single_valid", rsp_valid, 1);
    chk("single_p", rsp_p, 8382465);
    chk("single_id", rsp_id, 2);
    chk("single_busy_rsp", busy, 1);
    step();
    chk("single_done", rsp_valid, 0);
    chk("single_idle", busy, 0);

`ifndef DFT_MUL_ARB_FIXED_PRIO_EN
    // All requesters valid: strict rotation and in-order responses.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    for (int k = 0; k < 8; k++) begin
      req_valid = '1;
      #1;
      chk("rr_grant", req_ready, 1 << (k % 4));
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();
    chk("rr_count", log_p.size(), 8);
    for (int k = 0; k < 8 && k < log_p.size(); k++) begin
      chk("rr_p", log_p[k], 10 * ((k % 4) + 1));
      chk("rr_cycle", log_c[k], k + 4);
    end
`endif

    // Backpressure: six ops from requester 1, three-cycle stall on the first response.
    do_reset();
    issued = 0; stall_left = 0; stalled_once = 0; held = 0;
    set_op(1, $urandom_range(0, 2047), $urandom_range(0, 4095));
    for (int k = 0; k < 40; k++) begin
      req_valid = (issued < 6) ? 4'b0010 : 4'b0000;
      if (!stalled_once && rsp_valid) begin
        stall_left = 3;
        stalled_once = 1;
        held = int'(rsp_p);
      end
      rsp_ready = (stall_left == 0);
      if (stall_left > 0) begin
        chk("bp_hold_p", rsp_p, held);
        chk("bp_hold_valid", rsp_valid, 1);
      end
      #1;
      if (stall_left > 0) chk("bp_no_grant", req_ready, 0);
      acc = req_valid[1] && req_ready[1];
      step();
      if (acc) begin
        issued++;
        set_op(1, $urandom_range(0, 2047), $urandom_range(0, 4095));
      end
      if (stall_left > 0) stall_left--;
    end
    chk("bp_count", log_p.size(), 6);

    // Reset with three ops in flight.
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 5 + i, 9);
    req_valid = 4'b0111;
    for (int k = 0; k < 3; k++) step();
    chk("mid_busy", busy, 1);
    do_reset();
    set_op(0, 3, 3);
    req_valid = '1;
    #1;
    chk("mid_first_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();
    chk("mid_count", log_p.size(), 1);

    // Idle gaps between issues.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_op(3, 100 + k, 7);
      req_valid = (k == 0 || k == 5 || k == 6) ? 4'b1000 : 4'b0000;
      step();
    end
    chk("gap_count", log_c.size(), 3);
    if (log_c.size() == 3) begin
      chk("gap_c0", log_c[0], 4);
      chk("gap_c1", log_c[1], 9);
      chk("gap_c2", log_c[2], 10);
    end

`ifdef DFT_MUL_ARB_FIXED_PRIO_EN
    // Requester 0 always wins over requester 3.
    do_reset();
    set_op(0, 1, 1);
    set_op(3, 2, 2);
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b1001;
      #1;
      chk("fixed_grant", req_ready, 4'b0001);
      step();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) step();
`endif

    // Randomized traffic with random backpressure.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        set_op(i, ($urandom_range(0, 7) == 0) ? 2047 : int'($urandom_range(0, 2047)),
                  ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 4095)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("rand_drained", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
